// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one operand slice per stage, with a
// global-enable valid/ready pipe that freezes as a whole when the consumer stalls.
module cla_addsub_pipe #(
  parameter int nBITS   = 32,
  parameter int nSTAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nBITS-1:0] ain,
  input  logic [nBITS-1:0] bin,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nBITS-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int W    = nBITS / nSTAGES;
  localparam int LAST = nSTAGES - 1;

  // Returns {carry into slice MSB, slice carry out, slice sum}.
  function automatic logic [W+1:0] cla_slice(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic         c0);
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    p    = a ^ b;
    g    = a & b;
    c[0] = c0;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[W-1], c[W], p ^ c[W-1:0]};
  endfunction

  logic [nSTAGES-1:0] v_r;
  logic [nSTAGES-1:0] c_r;
  logic [nBITS-1:0]   a_r [nSTAGES];
  logic [nBITS-1:0]   b_r [nSTAGES];
  logic [nBITS-1:0]   s_r [nSTAGES];
  logic               ovf_r;

  logic [nSTAGES-1:0] vi_s;
  logic [nSTAGES-1:0] ci_s;
  logic [nBITS-1:0]   ai_s [nSTAGES];
  logic [nBITS-1:0]   bi_s [nSTAGES];
  logic [nBITS-1:0]   si_s [nSTAGES];
  logic [nBITS-1:0]   s_nxt_s [nSTAGES];
  logic [nSTAGES-1:0] c_nxt_s;
  logic               cm_last_s;
  logic [W+1:0]       res_s;
  logic               adv_s;

  // Stage inputs: stage 0 sees the (possibly inverted) operands, later stages the previous register.
  always_comb begin
    vi_s[0] = in_valid;
    ai_s[0] = ain;
    bi_s[0] = sub ? ~bin : bin;
    ci_s[0] = sub | cin;
    si_s[0] = {nBITS{1'b0}};
    for (int k = 1; k < nSTAGES; k++) begin
      vi_s[k] = v_r[k-1];
      ai_s[k] = a_r[k-1];
      bi_s[k] = b_r[k-1];
      ci_s[k] = c_r[k-1];
      si_s[k] = s_r[k-1];
    end
  end

  // Each stage resolves its own slice; the last one also yields the carry into the word MSB.
  always_comb begin
    cm_last_s = 1'b0;
    res_s     = {(W+2){1'b0}};
    for (int k = 0; k < nSTAGES; k++) begin
      res_s                = cla_slice(ai_s[k][k*W +: W], bi_s[k][k*W +: W], ci_s[k]);
      s_nxt_s[k]           = si_s[k];
      s_nxt_s[k][k*W +: W] = res_s[W-1:0];
      c_nxt_s[k]           = res_s[W];
      cm_last_s            = (k == LAST) ? res_s[W+1] : cm_last_s;
    end
  end

  assign adv_s    = out_ready | ~v_r[LAST];
  assign in_ready = adv_s;

  // Pipeline registers; the whole pipe advances together, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r   <= {nSTAGES{1'b0}};
      c_r   <= {nSTAGES{1'b0}};
      ovf_r <= 1'b0;
      for (int k = 0; k < nSTAGES; k++) begin
        a_r[k] <= {nBITS{1'b0}};
        b_r[k] <= {nBITS{1'b0}};
        s_r[k] <= {nBITS{1'b0}};
      end
    end else if (adv_s) begin
      v_r   <= vi_s;
      c_r   <= c_nxt_s;
      ovf_r <= cm_last_s ^ c_nxt_s[LAST];
      for (int k = 0; k < nSTAGES; k++) begin
        a_r[k] <= ai_s[k];
        b_r[k] <= bi_s[k];
        s_r[k] <= s_nxt_s[k];
      end
    end
  end

  assign out_valid = v_r[LAST];
  assign sum       = s_r[LAST];
  assign co        = c_r[LAST];
  assign ovf       = ovf_r;

endmodule
